fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] SHALL be 00).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction memory request, held high until imem_ack.
REQ-005 imem_addr  output  32  fetch address, stable while imem_req is high.
REQ-006 imem_ack  input  1  single-cycle response strobe; valid only while imem_req is high.
REQ-007 imem_rdata  input  32  instruction word, valid in the imem_ack cycle.
REQ-008 redirect_valid  input  1  branch-taken strobe from the branch datapath.
REQ-009 redirect_pc  input  32  branch target; bits [1:0] SHALL be ignored and treated as 00.
REQ-010 instr_valid  output  1  instruction available to decode.
REQ-011 instr_out  output  32  fetched instruction.
REQ-012 instr_pc  output  32  address of instr_out.
REQ-013 instr_ready  input  1  decode accepts instr_out.

Function
REQ-014 States: IDLE, FETCH, DRAIN, HOLD; registered state, Moore-style outputs.
REQ-015 IDLE: imem_req=0, instr_valid=0; next state SHALL always be FETCH.
REQ-016 FETCH: imem_req=1, imem_addr=pc.
REQ-017 FETCH, imem_ack=1 and redirect_valid=0: instr_out<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to HOLD.
REQ-018 FETCH, imem_ack=1 and redirect_valid=1: discard rdata, pc<=redirect_pc, stay in FETCH; the new address SHALL appear the next cycle.
REQ-019 FETCH, imem_ack=0 and redirect_valid=1: pending<=redirect_pc, go to DRAIN; imem_addr SHALL NOT change.
REQ-020 DRAIN: imem_req=1, imem_addr=old pc.
REQ-021 DRAIN, imem_ack=1: discard rdata, pc<=pending (or redirect_pc if redirect_valid is high that cycle), go to FETCH.
REQ-022 DRAIN, redirect_valid=1 without ack: pending<=redirect_pc (latest redirect wins).
REQ-023 HOLD: imem_req=0, instr_valid=1, and instr_out/instr_pc SHALL be stable.
REQ-024 Transfer occurs when instr_valid & instr_ready & ~redirect_valid; on transfer, instr_valid<=0 and the state goes to FETCH.
REQ-025 HOLD, redirect_valid=1: instr_valid<=0 regardless of instr_ready (no transfer), pc<=redirect_pc, go to FETCH.
REQ-026 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 SHALL wrap to 0.
REQ-027 Best-case throughput is one instruction per 2 cycles (FETCH ack then HOLD transfer); ack in the first FETCH cycle SHALL give instr_valid the next cycle.
REQ-028 imem_ack outside FETCH/DRAIN SHALL be ignored.

Reset
REQ-029 Reset asserted at any time, including mid-request: state=IDLE, pc=RESET_PC, pending=0, instr_out=0, instr_pc=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, effective immediately.
REQ-030 After reset deassertion: the first cycle is IDLE; imem_req=1 with imem_addr=RESET_PC from the second rising edge.
REQ-031 An in-flight request aborted by reset is dropped; the memory side SHALL tolerate the dropped request.

Structure
REQ-032 Shared package: state enum (IDLE, FETCH, DRAIN, HOLD), PC_INCR=32'd4, default RESET_PC, 32-bit word typedef.
REQ-033 One sub-module, fetch_pc_reg: PC register with next-PC select (hold / +4 / redirect / pending), async reset to RESET_PC.
REQ-034 No combinational path from imem_rdata to any output.

Verification
REQ-035 Reset, ack every FETCH cycle, instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8; instr_out matches the memory model.
REQ-036 instr_ready held 0 for 5 cycles in HOLD -> instr_valid/instr_out/instr_pc stable, imem_req=0 throughout.
REQ-037 Redirect to 0x100 during FETCH, ack delayed 3 cycles -> imem_addr stays at the old pc until ack, that data is discarded, next imem_addr=0x100.
REQ-038 Redirects to 0x200 then 0x300 during DRAIN -> next fetch address 0x300; redirect_pc=0x203 -> fetch address 0x200.
REQ-039 Redirect with instr_ready=1 in HOLD -> no transfer counted, instr_valid=0 next cycle, next fetch address=redirect target.
REQ-040 RESET_PC=32'hFFFF_FFFC -> second instr_pc=0x0; reset asserted mid-DRAIN -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_INCR          = 32'd4;
    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHold
    } state_t;

    typedef enum logic [1:0] {
        PcHold,
        PcIncr,
        PcRedirect,
        PcPending
    } pc_sel_t;

    // Force an address onto a word boundary.
    function automatic word_t word_align(word_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory port, branch redirect and decode handoff.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack;
    word_t imem_rdata;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  instr_valid;
    word_t instr_out;
    word_t instr_pc;
    logic  instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic    clk,
    input  logic    reset,
    input  pc_sel_t sel,
    input  word_t   redirect_pc,
    input  word_t   pending,
    output word_t   pc
);

    word_t pc_d;
    word_t pc_q;

    assign pc = pc_q;

    // Choose the next PC; increment wraps modulo 2^32.
    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            PcHold:     pc_d = pc_q;
            PcIncr:     pc_d = pc_q + PC_INCR;
            PcRedirect: pc_d = redirect_pc;
            PcPending:  pc_d = pending;
            default:    pc_d = pc_q;
        endcase
    end

    // PC state, asynchronously reset to the boot address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, branch redirect
// handling (including redirects that arrive while a request is in flight),
// and a single-entry output register towards decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    state_t  state_q;
    word_t   pc;
    word_t   pending_q;
    word_t   instr_out_q;
    word_t   instr_pc_q;
    logic    req_q;
    logic    valid_q;
    pc_sel_t pc_sel;
    word_t   redirect_tgt;

    assign redirect_tgt    = word_align(bus.redirect_pc);
    // The request address is the PC itself; it only moves on ack or from HOLD.
    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = valid_q;
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_pc    = instr_pc_q;

    // Decide how the PC advances this cycle.
    always_comb begin
        pc_sel = PcHold;
        unique case (state_q)
            StIdle:  pc_sel = PcHold;
            StFetch: if (bus.imem_ack) pc_sel = bus.redirect_valid ? PcRedirect : PcIncr;
            StDrain: if (bus.imem_ack) pc_sel = bus.redirect_valid ? PcRedirect : PcPending;
            StHold:  if (bus.redirect_valid) pc_sel = PcRedirect;
            default: pc_sel = PcHold;
        endcase
    end

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .sel        (pc_sel),
        .redirect_pc(redirect_tgt),
        .pending    (pending_q),
        .pc         (pc)
    );

    // Control FSM with registered request/valid outputs and the decode buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            instr_out_q <= '0;
            instr_pc_q  <= '0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    req_q   <= 1'b1;
                end
                StFetch: begin
                    if (bus.imem_ack && !bus.redirect_valid) begin
                        instr_out_q <= bus.imem_rdata;
                        instr_pc_q  <= pc;
                        valid_q     <= 1'b1;
                        req_q       <= 1'b0;
                        state_q     <= StHold;
                    end else if (!bus.imem_ack && bus.redirect_valid) begin
                        // Request must complete before the target can be fetched.
                        pending_q <= redirect_tgt;
                        state_q   <= StDrain;
                    end
                end
                StDrain: begin
                    if (bus.imem_ack) begin
                        state_q <= StFetch;
                    end else if (bus.redirect_valid) begin
                        pending_q <= redirect_tgt;
                    end
                end
                StHold: begin
                    // A redirect kills the held instruction even if decode is ready.
                    if (bus.redirect_valid || bus.instr_ready) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// compared against a transaction-level model of the fetch stream.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    fetch_unit #(
        .RESET_PC(32'hFFFF_FFFC)
    ) dut_wrap (
        .clk  (clk),
        .reset(reset2),
        .bus  (bus2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: address of the current/next request, whether that request is
    // already doomed by a redirect, and the instruction waiting for decode.
    bit    m_started;
    bit    m_have;
    bit    m_stale;
    word_t m_addr;
    word_t m_tgt;
    word_t m_out_pc;
    word_t m_out_data;

    function automatic word_t mem_word(word_t a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F ^ {a[7:0], a[31:8]};
    endfunction

    task automatic chk_word(string tag, word_t got, word_t exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_bit(string tag, logic got, logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic model_reset(word_t boot);
        m_started  = 1'b0;
        m_have     = 1'b0;
        m_stale    = 1'b0;
        m_addr     = boot;
        m_tgt      = '0;
        m_out_pc   = '0;
        m_out_data = '0;
    endtask

    task automatic model_step(bit ack, bit rv, word_t rpc, bit rdy);
        word_t t;
        t = rpc & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_have) begin
            if (rv) begin
                m_have = 1'b0;
                m_addr = t;
            end else if (rdy) begin
                m_have = 1'b0;
            end
        end else if (ack) begin
            if (rv) begin
                m_addr  = t;
                m_stale = 1'b0;
            end else if (m_stale) begin
                m_addr  = m_tgt;
                m_stale = 1'b0;
            end else begin
                m_have     = 1'b1;
                m_out_pc   = m_addr;
                m_out_data = mem_word(m_addr);
                m_addr     = m_addr + 32'd4;
            end
        end else if (rv) begin
            m_stale = 1'b1;
            m_tgt   = t;
        end
    endtask

    task automatic check_outputs();
        chk_bit("imem_req", bus.imem_req, m_started && !m_have);
        chk_bit("instr_valid", bus.instr_valid, m_have);
        if (m_started && !m_have) chk_word("imem_addr", bus.imem_addr, m_addr);
        if (m_have) begin
            chk_word("instr_pc", bus.instr_pc, m_out_pc);
            chk_word("instr_out", bus.instr_out, m_out_data);
        end
    endtask

    // Drive at the falling edge, let the rising edge act, check at the next falling edge.
    task automatic cycle(bit ack, bit rv, word_t rpc, bit rdy);
        bus.imem_ack       = ack;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = rdy;
        bus.imem_rdata     = ack ? mem_word(bus.imem_addr) : $urandom;
        @(posedge clk);
        model_step(ack, rv, rpc, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic chk_reset_values(string tag);
        chk_bit({tag, "_req"}, bus.imem_req, 1'b0);
        chk_bit({tag, "_valid"}, bus.instr_valid, 1'b0);
        chk_word({tag, "_addr"}, bus.imem_addr, 32'h0);
        chk_word({tag, "_out"}, bus.instr_out, 32'h0);
        chk_word({tag, "_pc"}, bus.instr_pc, 32'h0);
    endtask

    initial begin
        word_t seen_pc[$];
        word_t seen_data[$];
        int    guard;

        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.instr_ready     = 1'b0;
        bus2.imem_ack       = 1'b0;
        bus2.imem_rdata     = '0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.instr_ready    = 1'b0;
        model_reset(32'h0);

        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        check_outputs();

        // Back-to-back fetches: PC stream 0, 4, 8 (first cycle after reset is idle).
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            if (bus.instr_valid) seen_pc.push_back(bus.instr_pc);
        end
        chk_word("seq_len", word_t'(seen_pc.size()), 32'd3);
        chk_word("seq0", seen_pc.size() > 0 ? seen_pc[0] : 32'hDEAD_BEEF, 32'h0);
        chk_word("seq1", seen_pc.size() > 1 ? seen_pc[1] : 32'hDEAD_BEEF, 32'h4);
        chk_word("seq2", seen_pc.size() > 2 ? seen_pc[2] : 32'hDEAD_BEEF, 32'h8);
        chk_word("seq2_data", bus.instr_out, mem_word(32'h8));

        // Decode stalls for 5 cycles; stray acks must be ignored.
        for (int i = 0; i < 5; i++) begin
            cycle(1'(i % 2), 1'b0, 32'h0, 1'b0);
            chk_word("stall_pc", bus.instr_pc, 32'h8);
            chk_bit("stall_valid", bus.instr_valid, 1'b1);
            chk_bit("stall_req", bus.imem_req, 1'b0);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk_word("after_stall_addr", bus.imem_addr, 32'hC);

        // Redirect during FETCH with ack arriving 3 cycles later.
        cycle(1'b0, 1'b1, 32'h100, 1'b0);
        chk_word("drain_addr0", bus.imem_addr, 32'hC);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            chk_word("drain_addr", bus.imem_addr, 32'hC);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk_word("redirect_addr", bus.imem_addr, 32'h100);
        chk_bit("redirect_discard", bus.instr_valid, 1'b0);

        // Latest redirect during DRAIN wins; low target bits are ignored.
        cycle(1'b0, 1'b1, 32'h200, 1'b0);
        cycle(1'b0, 1'b1, 32'h300, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk_word("latest_wins", bus.imem_addr, 32'h300);
        cycle(1'b0, 1'b1, 32'h203, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk_word("align_tgt", bus.imem_addr, 32'h200);

        // Redirect while holding, with decode ready: instruction is dropped.
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk_word("hold_pc", bus.instr_pc, 32'h200);
        cycle(1'b0, 1'b1, 32'h400, 1'b1);
        chk_bit("hold_redir_valid", bus.instr_valid, 1'b0);
        chk_word("hold_redir_addr", bus.imem_addr, 32'h400);

        // Ack and redirect together in FETCH: stay fetching at the target.
        cycle(1'b1, 1'b1, 32'h600, 1'b0);
        chk_word("ack_redir_addr", bus.imem_addr, 32'h600);
        chk_bit("ack_redir_valid", bus.instr_valid, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom,
                  1'($urandom_range(0, 1)));
        end

        // Steer into FETCH, then into DRAIN, then reset between clock edges.
        guard = 0;
        while ((m_have || m_stale || !m_started) && guard < 20) begin
            cycle(m_stale, 1'b0, 32'h0, 1'b1);
            guard++;
        end
        chk_bit("reach_fetch", guard < 20, 1'b1);
        cycle(1'b0, 1'b1, 32'h500, 1'b0);
        chk_bit("in_drain_req", bus.imem_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_reset_values("async_reset");
        model_reset(32'h0);
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // PC wrap with a boot address at the top of the address space.
        @(negedge clk);
        reset2 = 1'b0;
        seen_pc.delete();
        seen_data.delete();
        for (int i = 0; i < 8; i++) begin
            bus2.imem_ack    = 1'b1;
            bus2.instr_ready = 1'b1;
            bus2.imem_rdata  = mem_word(bus2.imem_addr);
            @(negedge clk);
            if (bus2.instr_valid) begin
                seen_pc.push_back(bus2.instr_pc);
                seen_data.push_back(bus2.instr_out);
            end
        end
        chk_word("wrap_pc0", seen_pc.size() > 0 ? seen_pc[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk_word("wrap_data0", seen_data.size() > 0 ? seen_data[0] : 32'hDEAD_BEEF,
                 mem_word(32'hFFFF_FFFC));
        chk_word("wrap_pc1", seen_pc.size() > 1 ? seen_pc[1] : 32'hDEAD_BEEF, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
